stage_driver: RTL

Sequential controller that runs a multi-stage attempt through the combinational stage evaluator. It is the driving end of the evaluator's pass/bonus interface. Each stage it:
- draws the random `hard` and `luck` parameters from an LFSR;
- accepts one player `work` value over a valid/ready handshake;
- presents the carried pass/bonus plus the stage inputs to the evaluator;
- captures the evaluator's pass/bonus result as the carry into the next stage.

It reports stage index, completion, win/lose and accumulated bonus.

---
 rtl/stage_driver_pkg.sv | 24 ++
 rtl/stage_lfsr.sv | 24 ++
 rtl/stage_driver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stage_driver_pkg.sv
// Shared types and constants for the stage driver: FSM states, score limits
// and the 16-bit Fibonacci LFSR feedback.
package stage_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT_WORK,
        EVAL,
        DONE
    } state_t;

    localparam int SCORE_MAX = 100;
    localparam int WORK_W    = 7;
    localparam int BONUS_W   = 2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Feedback bit is the parity of the tapped bits (15, 13, 12, 10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stage_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
module stage_lfsr
    import stage_driver_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value
);

    // An all-zero state would lock the register up, so zero seeds become 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED_EFF;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/stage_driver.sv
// Drives a multi-stage attempt through the external stage evaluator, carrying
// pass/bonus from stage to stage and accumulating the result.
module stage_driver
    import stage_driver_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               work_valid,
    input  logic [WORK_W-1:0]  work,
    output logic               work_ready,
    output logic [WORK_W-1:0]  work_o,
    output logic [WORK_W-1:0]  hard,
    output logic [1:0]         luck,
    output logic               pass_o,
    output logic [BONUS_W-1:0] bonus_o,
    input  logic               pass_i,
    input  logic [BONUS_W-1:0] bonus_i,
    output logic [2:0]         stage_idx,
    output logic               done,
    output logic               win,
    output logic [4:0]         total_bonus
);

    localparam logic [2:0]        LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [WORK_W-1:0] SCORE_CAP  = WORK_W'(SCORE_MAX);

    state_t            state;
    logic              lfsr_step;
    logic [15:0]       lfsr_value;
    logic [15:0]       lfsr_peek;
    logic [WORK_W-1:0] hard_raw;
    logic [WORK_W-1:0] hard_mapped;
    logic [WORK_W-1:0] work_clamped;
    logic              unused_lfsr_bits;

    assign lfsr_step = (state == GEN);

    stage_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // The stage parameters come from the value the LFSR moves to at the GEN
    // edge, so they land in the same cycle as the register update.
    assign lfsr_peek        = lfsr_next(lfsr_value);
    assign hard_raw         = lfsr_peek[6:0];
    assign hard_mapped      = (hard_raw > SCORE_CAP) ? hard_raw - SCORE_CAP : hard_raw;
    assign work_clamped     = (work > SCORE_CAP) ? SCORE_CAP : work;
    assign unused_lfsr_bits = ^{lfsr_peek[15:10], lfsr_peek[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            work_ready  <= 1'b0;
            work_o      <= '0;
            hard        <= '0;
            luck        <= '0;
            pass_o      <= 1'b0;
            bonus_o     <= '0;
            stage_idx   <= '0;
            done        <= 1'b0;
            win         <= 1'b0;
            total_bonus <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stage_idx   <= '0;
                        total_bonus <= '0;
                        win         <= 1'b0;
                        done        <= 1'b0;
                        pass_o      <= 1'b1;
                        bonus_o     <= '0;
                        state       <= GEN;
                    end
                end
                GEN: begin
                    hard       <= hard_mapped;
                    luck       <= lfsr_peek[9:8];
                    work_ready <= 1'b1;
                    state      <= WAIT_WORK;
                end
                WAIT_WORK: begin
                    if (work_valid) begin
                        work_o     <= work_clamped;
                        work_ready <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    // A failed stage ends the attempt and drops the carry.
                    if (!pass_i) begin
                        pass_o  <= 1'b0;
                        bonus_o <= '0;
                        win     <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        total_bonus <= total_bonus + 5'(bonus_i);
                        pass_o      <= 1'b1;
                        bonus_o     <= bonus_i;
                        if (stage_idx == LAST_STAGE) begin
                            win   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            stage_idx <= stage_idx + 3'd1;
                            state     <= GEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
